// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, bit timing, LSB-first deserialise, parity/stop check.
// data_valid rises 1 + P*(2+DATA_WIDTH+PAR_EN) cycles after IDLE sees RX_IN low; no backpressure.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  parameter int EDGE_W     = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [EDGE_W-1:0]     edge_count,
  output logic [3:0]            bit_count,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_e                  state_q;
  logic [EDGE_W-1:0]       edge_q;
  logic [3:0]              bit_q;
  logic [PRESC_W-1:0]      presc_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic                    par_acc_q;
  logic                    par_flag_q;
  logic [DATA_WIDTH-1:0]   p_data_q;
  logic                    samp_en_q;
  logic                    busy_q;
  logic                    data_valid_q;
  logic                    par_err_q;
  logic                    stp_err_q;

  logic                    presc_legal;
  logic [EDGE_W-1:0]       edge_last;
  logic                    bit_end;
  logic                    par_exp;

  assign presc_legal = (Prescale == PRESC_W'(4))  || (Prescale == PRESC_W'(8)) ||
                       (Prescale == PRESC_W'(16)) || (Prescale == PRESC_W'(32));
  // Truncation maps a latched 32 to 31 in the EDGE_W-bit counter domain.
  assign edge_last   = EDGE_W'(presc_q - PRESC_W'(1));
  assign bit_end     = (edge_q == edge_last);
  assign par_exp     = par_typ_q ? ~par_acc_q : par_acc_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      edge_q       <= '0;
      bit_q        <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      shreg_q      <= '0;
      par_acc_q    <= 1'b0;
      par_flag_q   <= 1'b0;
      p_data_q     <= '0;
      samp_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      if (state_q == S_IDLE) begin
        edge_q <= '0;
        bit_q  <= '0;
        if (!RX_IN && presc_legal) begin
          state_q    <= S_START;
          presc_q    <= Prescale;
          par_en_q   <= PAR_EN;
          par_typ_q  <= PAR_TYP;
          shreg_q    <= '0;
          par_acc_q  <= 1'b0;
          par_flag_q <= 1'b0;
          samp_en_q  <= 1'b1;
          busy_q     <= 1'b1;
        end
      end else begin
        edge_q <= bit_end ? '0 : edge_q + 1'b1;
        if (bit_end) begin
          case (state_q)
            S_START: begin
              if (!sampled_bit) begin
                state_q <= S_DATA;
                bit_q   <= '0;
              end else begin
                state_q   <= S_IDLE;
                bit_q     <= '0;
                samp_en_q <= 1'b0;
                busy_q    <= 1'b0;
              end
            end
            S_DATA: begin
              shreg_q   <= {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
              par_acc_q <= par_acc_q ^ sampled_bit;
              if (bit_q == LAST_BIT) begin
                state_q <= par_en_q ? S_PARITY : S_STOP;
              end else begin
                bit_q <= bit_q + 4'd1;
              end
            end
            S_PARITY: begin
              par_flag_q <= (sampled_bit != par_exp);
              state_q    <= S_STOP;
            end
            S_STOP: begin
              if (!par_flag_q && sampled_bit) begin
                data_valid_q <= 1'b1;
                p_data_q     <= shreg_q;
              end else begin
                par_err_q <= par_flag_q;
                stp_err_q <= ~sampled_bit;
              end
              bit_q <= '0;
              // A low line at the stop bit end is the next frame's start bit.
              if (!RX_IN) begin
                state_q    <= S_START;
                shreg_q    <= '0;
                par_acc_q  <= 1'b0;
                par_flag_q <= 1'b0;
              end else begin
                state_q   <= S_IDLE;
                samp_en_q <= 1'b0;
                busy_q    <= 1'b0;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign dat_samp_en = samp_en_q;
  assign edge_count  = edge_q;
  assign bit_count   = bit_q;
  assign busy        = busy_q;
  assign P_DATA      = p_data_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives RX_IN and an ideal sampled_bit aligned to the FSM bit windows.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       sampled_bit = 1'b1;
  logic       dat_samp_en;
  logic [4:0] edge_count;
  logic [3:0] bit_count;
  logic       busy;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .sampled_bit (sampled_bit),
    .dat_samp_en (dat_samp_en),
    .edge_count  (edge_count),
    .bit_count   (bit_count),
    .busy        (busy),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int c0;

  int         dv_cnt, dv_cyc, dv_cyc1, par_cnt, par_cyc, stp_cnt, stp_cyc;
  logic [7:0] dv_dat, dv_dat1;
  logic       dv_busy1;

  always @(negedge CLK) begin
    if (data_valid === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc;
      dv_dat = P_DATA;
      if (dv_cnt == 1) begin
        dv_cyc1  = cyc;
        dv_dat1  = P_DATA;
        dv_busy1 = busy;
      end
    end
    if (par_err === 1'b1) begin
      par_cnt = par_cnt + 1;
      par_cyc = cyc;
    end
    if (stp_err === 1'b1) begin
      stp_cnt = stp_cnt + 1;
      stp_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    dv_cnt = 0; dv_cyc = 0; dv_cyc1 = 0; dv_dat = '0; dv_dat1 = '0; dv_busy1 = 1'b0;
    par_cnt = 0; par_cyc = 0; stp_cnt = 0; stp_cyc = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One bit window of p cycles; rx_last is the line level in the bit-end cycle.
  task automatic drive_win(input logic rx, input logic samp, input int p, input logic rx_last);
    RX_IN = rx;
    sampled_bit = samp;
    if (p > 1) tick(p - 1);
    RX_IN = rx_last;
    tick(1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pbit,
                            input logic stop_samp, input logic stop_rx_last, input logic detect);
    if (detect) begin
      RX_IN = 1'b0;
      c0 = cyc;
      tick(1);
    end
    drive_win(1'b0, 1'b0, p, 1'b0);
    for (int i = 0; i < 8; i++) drive_win(d[i], d[i], p, d[i]);
    if (pe) drive_win(pbit, pbit, p, pbit);
    drive_win(1'b1, stop_samp, p, stop_rx_last);
    RX_IN = 1'b1;
    sampled_bit = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c_first;
    clr();
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_samp_en", dat_samp_en, 0);
    check("rst_pdata", P_DATA, 0);
    check("rst_edge", edge_count, 0);
    check("rst_bitcnt", bit_count, 0);
    check("rst_pulses", {data_valid, par_err, stp_err}, 0);
    RST = 1'b1;
    tick(2);

    // Clean frame, P=8, no parity
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clr();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    check("f1_dv_cnt", dv_cnt, 1);
    check("f1_latency", dv_cyc - c0, 81);
    check("f1_dv_data", dv_dat, 8'hA5);
    check("f1_pdata", P_DATA, 8'hA5);
    check("f1_errs", par_cnt + stp_cnt, 0);
    check("f1_idle", busy, 0);

    // Parity error: even parity, 0x3C needs 0, line carries 1
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clr();
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    check("par_cnt", par_cnt, 1);
    check("par_cyc", par_cyc - c0, 89);
    check("par_no_dv", dv_cnt, 0);
    check("par_no_stp", stp_cnt, 0);
    check("par_pdata_hold", P_DATA, 8'hA5);

    // Stop error, P=16: sampler votes 0 while the line ends high
    Prescale = 6'd16; PAR_EN = 1'b0;
    clr();
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    check("stp_cnt", stp_cnt, 1);
    check("stp_cyc", stp_cyc - c0, 161);
    check("stp_no_dv", dv_cnt, 0);
    check("stp_no_par", par_cnt, 0);
    check("stp_idle", busy, 0);
    check("stp_pdata_hold", P_DATA, 8'hA5);

    // False start, P=8
    Prescale = 6'd8;
    clr();
    RX_IN = 1'b0;
    c0 = cyc;
    tick(1);
    RX_IN = 1'b1; sampled_bit = 1'b1;
    tick(7);
    check("fs_busy_end", busy, 1);
    check("fs_edge_end", edge_count, 7);
    tick(1);
    check("fs_idle", busy, 0);
    check("fs_samp_off", dat_samp_en, 0);
    tick(2);
    check("fs_no_pulse", dv_cnt + par_cnt + stp_cnt, 0);

    // Back-to-back, P=32, odd parity: 0x00 then 0xFF, parity bit 1 for both
    Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    clr();
    send_frame(8'h00, 32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    c_first = c0;
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    check("b2b_dv_cnt", dv_cnt, 2);
    check("b2b_lat1", dv_cyc1 - c_first, 353);
    check("b2b_gap", dv_cyc - dv_cyc1, 352);
    check("b2b_dat1", dv_dat1, 8'h00);
    check("b2b_busy_at_dv1", dv_busy1, 1);
    check("b2b_dat2", P_DATA, 8'hFF);
    check("b2b_errs", par_cnt + stp_cnt, 0);

    // Reset in the middle of data bit 3
    Prescale = 6'd8; PAR_EN = 1'b0;
    clr();
    RX_IN = 1'b0;
    tick(1);
    drive_win(1'b0, 1'b0, 8, 1'b0);
    drive_win(1'b0, 1'b0, 8, 1'b0);
    drive_win(1'b1, 1'b1, 8, 1'b1);
    drive_win(1'b0, 1'b0, 8, 1'b0);
    RX_IN = 1'b1; sampled_bit = 1'b1;
    tick(2);
    check("mid_bitcnt", bit_count, 3);
    check("mid_edge", edge_count, 2);
    RST = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_samp_en", dat_samp_en, 0);
    check("arst_bitcnt", bit_count, 0);
    check("arst_edge", edge_count, 0);
    check("arst_pdata", P_DATA, 0);
    tick(1);
    RST = 1'b1;
    tick(12);
    check("arst_no_pulse", dv_cnt + par_cnt + stp_cnt, 0);
    check("arst_idle", busy, 0);

    // Illegal prescale keeps the FSM parked
    Prescale = 6'd5;
    RX_IN = 1'b0;
    tick(20);
    check("bad_presc_busy", busy, 0);
    check("bad_presc_samp", dat_samp_en, 0);
    check("bad_presc_edge", edge_count, 0);
    RX_IN = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
